// File: rtl/vector_ring_pkg.sv
// vector_ring_pkg: shared defaults, lane types and ring-pointer helpers for vector_bank_ring.
package vector_ring_pkg;
    localparam int DEF_LENGTH      = 1024;
    localparam int DEF_DATA_WIDTH  = 32;
    localparam int DEF_PARALLELISM = 4;
    localparam int DEF_NUM_BANKS   = 3;
    localparam int DEF_ADDR_W      = $clog2(DEF_LENGTH);

    typedef logic [DEF_ADDR_W-1:0]     lane_addr_t;
    typedef logic [DEF_DATA_WIDTH-1:0] lane_data_t;

    function automatic int bank_w(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

    function automatic int ptr_inc(input int p, input int n);
        return (p == n - 1) ? 0 : p + 1;
    endfunction
endpackage

// File: rtl/vector_bank.sv
// vector_bank: one LENGTH-deep vector bank with masked parallel write lanes and combinational read lanes.
module vector_bank #(
    parameter int LENGTH      = 1024,
    parameter int DATA_WIDTH  = 32,
    parameter int PARALLELISM = 4,
    parameter int ADDR_W      = $clog2(LENGTH)
) (
    input  logic                              clk,
    input  logic                              we_i,
    input  logic [PARALLELISM-1:0]            mask_i,
    input  logic [PARALLELISM*ADDR_W-1:0]     waddr_i,
    input  logic [PARALLELISM*DATA_WIDTH-1:0] wdata_i,
    input  logic [PARALLELISM*ADDR_W-1:0]     raddr_i,
    output logic [PARALLELISM*DATA_WIDTH-1:0] rdata_o
);
    logic [DATA_WIDTH-1:0] mem_q [LENGTH];

    // later lanes overwrite earlier ones, so the highest lane wins on an address clash
    always_ff @(posedge clk) begin
        if (we_i)
            for (int i = 0; i < PARALLELISM; i++)
                if (mask_i[i]) mem_q[waddr_i[i*ADDR_W +: ADDR_W]] <= wdata_i[i*DATA_WIDTH +: DATA_WIDTH];
    end

    for (genvar l = 0; l < PARALLELISM; l++) begin : g_rd
        assign rdata_o[l*DATA_WIDTH +: DATA_WIDTH] = mem_q[raddr_i[l*ADDR_W +: ADDR_W]];
    end
endmodule

// File: rtl/vector_bank_ring.sv
// vector_bank_ring: ring of vector banks between an SpMV iterate producer and consumer,
// with commit/release handshakes, occupancy tracking and read-data backpressure.
module vector_bank_ring
    import vector_ring_pkg::*;
#(
    parameter int LENGTH      = DEF_LENGTH,
    parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
    parameter int PARALLELISM = DEF_PARALLELISM,
    parameter int NUM_BANKS   = DEF_NUM_BANKS,
    parameter int ADDR_W      = $clog2(LENGTH),
    parameter int BANK_W      = bank_w(NUM_BANKS)
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              wr_valid,
    output logic                              wr_ready,
    input  logic [PARALLELISM*ADDR_W-1:0]     wr_addr,
    input  logic [PARALLELISM*DATA_WIDTH-1:0] wr_data,
    input  logic [PARALLELISM-1:0]            wr_mask,
    input  logic                              wr_commit,
    input  logic                              rd_valid,
    output logic                              rd_ready,
    input  logic [PARALLELISM*ADDR_W-1:0]     rd_addr,
    output logic                              rd_rvalid,
    input  logic                              rd_rready,
    output logic [PARALLELISM*DATA_WIDTH-1:0] rd_rdata,
    input  logic                              rd_release,
    output logic [BANK_W:0]                   occupancy,
    output logic [BANK_W-1:0]                 wr_bank,
    output logic [BANK_W-1:0]                 rd_bank,
    output logic                              err
);
    logic [BANK_W-1:0]                 wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [BANK_W:0]                   occ_q, occ_d;
    logic                              rvalid_q, rvalid_d, err_q, err_d;
    logic [PARALLELISM*DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic [PARALLELISM*DATA_WIDTH-1:0] bank_rdata [NUM_BANKS];
    logic                              full, empty, wr_fire, rd_fire, commit_ok, release_ok;

    assign full       = occ_q == (BANK_W+1)'(NUM_BANKS);
    assign empty      = occ_q == '0;
    assign wr_ready   = !full;
    assign rd_ready   = !empty && (!rvalid_q || rd_rready);
    assign wr_fire    = wr_valid && wr_ready;
    assign rd_fire    = rd_valid && rd_ready;
    assign release_ok = rd_release && !empty;
    // a release in the same cycle frees the slot a commit on a full ring needs
    assign commit_ok  = wr_commit && (!full || release_ok);

    for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
        vector_bank #(
            .LENGTH(LENGTH), .DATA_WIDTH(DATA_WIDTH), .PARALLELISM(PARALLELISM), .ADDR_W(ADDR_W)
        ) u_bank (
            .clk     (clk),
            .we_i    (wr_fire && wr_ptr_q == BANK_W'(b)),
            .mask_i  (wr_mask),
            .waddr_i (wr_addr),
            .wdata_i (wr_data),
            .raddr_i (rd_addr),
            .rdata_o (bank_rdata[b])
        );
    end

    always_comb begin
        wr_ptr_d = commit_ok ? BANK_W'(ptr_inc(int'(wr_ptr_q), NUM_BANKS)) : wr_ptr_q;
        rd_ptr_d = release_ok ? BANK_W'(ptr_inc(int'(rd_ptr_q), NUM_BANKS)) : rd_ptr_q;
        occ_d    = occ_q + (BANK_W+1)'(commit_ok) - (BANK_W+1)'(release_ok);
        err_d    = err_q || (wr_commit && !commit_ok) || (rd_release && !release_ok);
        rvalid_d = rd_fire || (rvalid_q && !rd_rready);
        rdata_d  = rd_fire ? bank_rdata[rd_ptr_q] : rdata_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            occ_q    <= occ_d;
            rvalid_q <= rvalid_d;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
        end
    end

    assign occupancy = occ_q;
    assign wr_bank   = wr_ptr_q;
    assign rd_bank   = rd_ptr_q;
    assign rd_rvalid = rvalid_q;
    assign rd_rdata  = rdata_q;
    assign err       = err_q;
endmodule

// File: tb/tb_vector_bank_ring.sv
// tb_vector_bank_ring: directed stimulus checked every cycle against a behavioural ring model plus literal expectations.
module tb_vector_bank_ring;
    localparam int NB = 3, P = 4, D = 32, A = 10, LEN = 1024;

    logic           clk = 1'b0, rst;
    logic           wr_valid, wr_ready, wr_commit, rd_valid, rd_ready, rd_rvalid, rd_rready, rd_release, err;
    logic [P*A-1:0] wr_addr, rd_addr;
    logic [P*D-1:0] wr_data, rd_rdata;
    logic [P-1:0]   wr_mask;
    logic [2:0]     occupancy;
    logic [1:0]     wr_bank, rd_bank;

    vector_bank_ring #(.LENGTH(LEN), .DATA_WIDTH(D), .PARALLELISM(P), .NUM_BANKS(NB)) dut (
        .clk(clk), .rst(rst), .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr),
        .wr_data(wr_data), .wr_mask(wr_mask), .wr_commit(wr_commit), .rd_valid(rd_valid),
        .rd_ready(rd_ready), .rd_addr(rd_addr), .rd_rvalid(rd_rvalid), .rd_rready(rd_rready),
        .rd_rdata(rd_rdata), .rd_release(rd_release), .occupancy(occupancy), .wr_bank(wr_bank),
        .rd_bank(rd_bank), .err(err)
    );

    always #5 clk = ~clk;

    int n_chk = 0, n_pass = 0;
    bit started = 0;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h want %0h", nm, act, exp);
    endtask

    // model: bank contents as plain arrays, ring state as integers
    logic [D-1:0]   m_mem [NB][LEN];
    bit             m_wrt [NB][LEN];
    int             m_occ, m_wp, m_rp;
    bit             m_err, m_rv, m_known;
    logic [P*D-1:0] m_rd;

    always @(posedge clk) begin : model
        bit acc, rel, com;
        if (rst) begin
            m_occ = 0; m_wp = 0; m_rp = 0; m_err = 0; m_rv = 0; m_rd = '0; m_known = 1;
        end else begin
            acc = rd_valid && m_occ > 0 && (!m_rv || rd_rready);
            if (wr_valid && m_occ < NB)
                for (int l = 0; l < P; l++)
                    if (wr_mask[l]) begin
                        m_mem[m_wp][wr_addr[l*A +: A]] = wr_data[l*D +: D];
                        m_wrt[m_wp][wr_addr[l*A +: A]] = 1;
                    end
            if (acc) begin
                m_rv = 1; m_known = 1;
                for (int l = 0; l < P; l++) begin
                    m_rd[l*D +: D] = m_mem[m_rp][rd_addr[l*A +: A]];
                    m_known &= m_wrt[m_rp][rd_addr[l*A +: A]];
                end
            end else if (rd_rready) m_rv = 0;
            rel = rd_release && m_occ > 0;
            com = wr_commit && (m_occ < NB || rel);
            if ((wr_commit && !com) || (rd_release && !rel)) m_err = 1;
            if (com) m_wp = (m_wp + 1) % NB;
            if (rel) m_rp = (m_rp + 1) % NB;
            m_occ = m_occ + int'(com) - int'(rel);
        end
    end

    initial forever begin
        @(posedge clk); #1;
        if (started) begin
            chk("occupancy", occupancy, m_occ);
            chk("wr_bank", wr_bank, m_wp);
            chk("rd_bank", rd_bank, m_rp);
            chk("err", err, m_err);
            chk("rd_rvalid", rd_rvalid, m_rv);
            chk("wr_ready", wr_ready, m_occ < NB);
            chk("rd_ready", rd_ready, m_occ > 0 && (!m_rv || rd_rready));
            if (m_rv && m_known) chk("rd_rdata", rd_rdata, m_rd);
        end
    end

    task automatic tick();
        @(posedge clk); #2;
    endtask

    task automatic idle();
        wr_valid = 0; wr_commit = 0; rd_valid = 0; rd_release = 0; rd_rready = 1; wr_mask = '0;
    endtask

    task automatic do_reset();
        rst = 1; idle(); tick(); rst = 0;
    endtask

    initial begin
        rst = 1; idle(); wr_addr = '0; wr_data = '0; rd_addr = '0;
        started = 1;
        tick(); tick(); rst = 0;
        chk("rst occupancy", occupancy, 0);
        chk("rst wr_bank", wr_bank, 0);
        chk("rst rd_bank", rd_bank, 0);
        chk("rst rd_rvalid", rd_rvalid, 0);
        chk("rst rd_rdata", rd_rdata, 0);
        chk("rst err", err, 0);
        // basic fill, lane clash, commit, read back
        wr_valid = 1; wr_mask = 4'hF;
        wr_addr = {10'd3, 10'd2, 10'd1, 10'd0}; wr_data = {32'd13, 32'd12, 32'd11, 32'd10}; tick();
        wr_addr = {4{10'd9}}; wr_data = {32'd4, 32'd3, 32'd2, 32'd1}; wr_mask = 4'b0111; tick();
        wr_valid = 0; wr_commit = 1; tick(); wr_commit = 0;
        chk("commit occupancy", occupancy, 1);
        chk("commit wr_bank", wr_bank, 1);
        rd_valid = 1; rd_addr = {10'd0, 10'd1, 10'd2, 10'd3}; #1;
        chk("read ready", rd_ready, 1);
        tick();
        chk("read rvalid", rd_rvalid, 1);
        chk("read data", rd_rdata, {32'd10, 32'd11, 32'd12, 32'd13});
        rd_addr = {4{10'd9}}; tick();
        chk("lane clash data", rd_rdata, {4{32'd3}});
        rd_valid = 0; rd_release = 1; tick(); rd_release = 0;
        chk("release occupancy", occupancy, 0);
        chk("release rd_bank", rd_bank, 1);
        chk("release rvalid drop", rd_rvalid, 0);
        // empty ring
        do_reset();
        rd_valid = 1; #1;
        chk("empty rd_ready", rd_ready, 0);
        tick();
        chk("empty rvalid", rd_rvalid, 0);
        rd_valid = 0; rd_release = 1; tick(); rd_release = 0;
        chk("empty release err", err, 1);
        chk("empty release rd_bank", rd_bank, 0);
        // fill to full, rotate, overflow
        do_reset();
        for (int b = 0; b < NB; b++) begin
            wr_valid = 1; wr_mask = 4'h1; wr_addr = {4{10'd5}}; wr_data = {96'd0, 32'(100 + b)};
            wr_commit = 1; tick();
        end
        idle();
        chk("full occupancy", occupancy, 3);
        chk("full wr_ready", wr_ready, 0);
        chk("full wr_bank", wr_bank, 0);
        for (int k = 1; k <= NB; k++) begin
            wr_commit = 1; rd_release = 1; tick();
            chk("rotate occupancy", occupancy, 3);
            chk("rotate err", err, 0);
            chk("rotate wr_bank", wr_bank, k % NB);
            chk("rotate rd_bank", rd_bank, k % NB);
        end
        rd_release = 0; tick(); wr_commit = 0;
        chk("overflow err", err, 1);
        chk("overflow wr_bank", wr_bank, 0);
        chk("overflow occupancy", occupancy, 3);
        // backpressure with release under held data
        do_reset();
        wr_valid = 1; wr_mask = 4'hF; wr_addr = {4{10'd7}}; wr_data = {4{32'd70}}; wr_commit = 1; tick();
        wr_data = {4{32'd71}}; tick();
        idle();
        chk("two banks occupancy", occupancy, 2);
        rd_valid = 1; rd_addr = {4{10'd7}}; rd_rready = 0; tick();
        chk("bp first data", rd_rdata, {4{32'd70}});
        rd_release = 1; tick(); rd_release = 0;
        chk("bp release rd_bank", rd_bank, 1);
        for (int k = 0; k < 3; k++) begin
            #1; chk("bp rd_ready", rd_ready, 0);
            tick();
            chk("bp held data", rd_rdata, {4{32'd70}});
            chk("bp held rvalid", rd_rvalid, 1);
        end
        rd_rready = 1; #1;
        chk("bp resume ready", rd_ready, 1);
        tick();
        chk("bp next data", rd_rdata, {4{32'd71}});
        // reset mid-operation
        rd_valid = 0; rd_rready = 0; wr_commit = 1; tick(); wr_commit = 0;
        chk("pre-rst occupancy", occupancy, 2);
        chk("pre-rst rvalid", rd_rvalid, 1);
        do_reset();
        chk("mid-rst rvalid", rd_rvalid, 0);
        chk("mid-rst occupancy", occupancy, 0);
        chk("mid-rst err", err, 0);
        chk("mid-rst wr_bank", wr_bank, 0);
        chk("mid-rst rd_bank", rd_bank, 0);
        tick(); tick();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
